// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter/rotator (SHR, SHRA, SHL, ROR, ROL) for the ALU stage.
// Ports: clock/clear, start/op/a/b request; busy/done/err/result status.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(WIDTH);

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [AW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [AW-1:0]    s;
  logic [WIDTH-1:0] nxt;
  logic             b_unused;

  function automatic logic legal(
    input logic [2:0] o
  );
    return o <= OP_ROL;
  endfunction

  // Only the low AW bits of b form the amount.
  assign b_unused = ^b[WIDTH-1:AW];

  // Step never exceeds the remaining count.
  assign s = (int'(cnt) < STEP) ? cnt
                                : AW'(STEP);

  always_comb begin
    nxt = acc;
    unique case (1'b1)
      op_q == OP_SHR:
        nxt = acc >> s;
      op_q == OP_SHRA:
        nxt = $unsigned($signed(acc) >>> s);
      op_q == OP_SHL:
        nxt = acc << s;
      op_q == OP_ROR:
        nxt = (acc >> s)
            | (acc << (WIDTH - int'(s)));
      op_q == OP_ROL:
        nxt = (acc << s)
            | (acc >> (WIDTH - int'(s)));
      default:
        nxt = acc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= a;
            cnt  <= b[AW-1:0];
            op_q <= op;
            busy <= 1'b1;
            if (b[AW-1:0] != '0 && legal(op))
              state <= SHIFT;
            else
              state <= DONE;
          end
        end
        SHIFT: begin
          acc <= nxt;
          cnt <= cnt - s;
          if (cnt == s)
            state <= DONE;
        end
        DONE: begin
          done   <= 1'b1;
          result <= acc;
          err    <= ~legal(op_q);
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
